multicycle_control_fsm: RTL

- Multicycle main controller for the 16-bit RISC-V processor.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath muxes and write enables.
- Produces the 3-bit ALUControl consumed by the ALU, with the ALU encoding 000 add, 001 sub, 010 and, 011 or, 101 slt.
- Takes the ALU Zero flag back for branch resolution.

---
 rtl/multicycle_control_fsm.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle main controller for the 16-bit RISC-V core.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// drives the datapath mux selects and write enables, decodes the 3-bit
// ALU operation and resolves beq using the ALU Zero flag.
// Outputs are Moore-style: combinational from the registered state plus the
// current instruction fields (ImmSrc, ALUControl) and Zero (PCWrite in BEQ).

module multicycle_control_fsm #(
    // 1: an unknown opcode parks the controller in TRAP until reset.
    // 0: an unknown opcode is treated as a nop and fetch resumes.
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    // State encoding is visible on the debug port, so it is fixed here.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t     r_state;
    state_t     w_next_state;

    // Raw per-state controls before the reset gating of the write enables.
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_illegal;
    logic [1:0] w_imm_src;
    logic [2:0] w_alu_control;
    logic       w_sub_r;

    // State register; asynchronous reset returns straight to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; op is only consulted in DECODE and MEMADR.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_JAL:      w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Per-state datapath controls; anything not set for a state stays 0.
    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC + instruction size computed on the ALU and routed
                // straight back to the PC through ALUResult.
                w_ir_write   = 1'b1;
                w_alu_src_a  = 2'b00;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_update  = 1'b1;
            end
            S_DECODE: begin
                // Speculative branch/jump target OldPC + imm into ALUOut.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
                w_mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b00;
                w_alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_result_src = 2'b00;
                w_reg_write  = 1'b1;
            end
            S_BEQ: begin
                // ALUOut still holds the target from DECODE; the ALU
                // compares rs1 - rs2 and Zero decides the PC load.
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b00;
                w_alu_op     = 2'b01;
                w_result_src = 2'b00;
                w_branch     = 1'b1;
            end
            S_JAL: begin
                // PC takes the target in ALUOut while the ALU forms the
                // link address for the following ALUWB.
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b00;
                w_pc_update  = 1'b1;
            end
            S_TRAP: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_illegal = 1'b0;
            end
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        w_imm_src = 2'b00;
        case (op)
            OP_LW, OP_I: w_imm_src = 2'b00;
            OP_SW:       w_imm_src = 2'b01;
            OP_BEQ:      w_imm_src = 2'b10;
            OP_JAL:      w_imm_src = 2'b11;
            default:     w_imm_src = 2'b00;
        endcase
    end

    // Subtract only for R-type with bit 30 set; I-type addi never subtracts.
    assign w_sub_r = op[5] & funct7b5;

    // ALU decoder: ALUOp plus funct fields to the ALU operation code.
    always_comb begin
        w_alu_control = 3'b000;
        case (w_alu_op)
            2'b00: w_alu_control = 3'b000;
            2'b01: w_alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  w_alu_control = w_sub_r ? 3'b001 : 3'b000;
                    3'b010:  w_alu_control = 3'b101;
                    3'b110:  w_alu_control = 3'b011;
                    3'b111:  w_alu_control = 3'b010;
                    default: w_alu_control = 3'b000;
                endcase
            end
            default: w_alu_control = 3'b000;
        endcase
    end

    // Write enables are masked by reset directly so that asserting reset
    // kills any in-flight write without waiting for the state to settle.
    assign PCWrite    = ~reset & (w_pc_update | (w_branch & Zero));
    assign IRWrite    = ~reset & w_ir_write;
    assign RegWrite   = ~reset & w_reg_write;
    assign MemWrite   = ~reset & w_mem_write;
    assign AdrSrc     = w_adr_src;
    assign ResultSrc  = w_result_src;
    assign ALUSrcA    = w_alu_src_a;
    assign ALUSrcB    = w_alu_src_b;
    assign ImmSrc     = w_imm_src;
    assign ALUControl = w_alu_control;
    assign illegal    = w_illegal;
    assign state      = r_state;

endmodule
